// File: rtl/tick_divider_ctrl.sv
// rtl/tick_divider_ctrl.sv - multi-channel tick/square divider with RUN/STOP/STEP control
// Optional push-button debounce on the step input when STEP_DEBOUNCE_EN is defined.
module tick_divider_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 10000000,
  parameter int SEL_W       = 1,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              run,
  input  logic              step_btn,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [1:0]        mode
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_STOP = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             count_en;
  logic             step_fire;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] div_q [NUM_CH];
  logic [1:0]       sync_q;
  logic             btn_level;
  logic             level_prev_q;
  logic             step_pulse_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DEB_W-1:0] deb_cnt_q;
  logic             deb_level_q;

  // Level only follows the synchronised button after DEB_CYCLES stable samples.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else if (sync_q[1] == deb_level_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt_q   <= '0;
      deb_level_q <= sync_q[1];
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  assign btn_level = deb_level_q;
`else
  assign btn_level = sync_q[1];
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      level_prev_q <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      level_prev_q <= btn_level;
      step_pulse_q <= btn_level & ~level_prev_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // run has priority over a pending step; pulses outside STOP are dropped.
  always_comb begin
    state_d   = state_q;
    count_en  = 1'b0;
    step_fire = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        count_en = run;
        if (!run) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step_pulse_q) begin
          state_d   = ST_STEP;
          step_fire = 1'b1;
        end
      end
      ST_STEP: state_d = run ? ST_RUN : ST_STOP;
      default: state_d = ST_RUN;
    endcase
  end

  assign mode = state_q;

  // A divisor write overrides both the step and the terminal count on its channel.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_we && (div_sel == SEL_W'(i))) begin
          div_q[i] <= div_data;
          cnt_q[i] <= '0;
          tick[i]  <= 1'b0;
        end else if (step_fire) begin
          cnt_q[i] <= '0;
          tick[i]  <= 1'b1;
          sq[i]    <= ~sq[i];
        end else if (count_en) begin
          if (cnt_q[i] == div_q[i]) begin
            cnt_q[i] <= '0;
            tick[i]  <= 1'b1;
            sq[i]    <= ~sq[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            tick[i]  <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_divider_ctrl.sv
// tb/tb_tick_divider_ctrl.sv - scoreboard bench for tick_divider_ctrl
module tb_tick_divider_ctrl;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DEF    = 3;
  localparam int DEB    = 4;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic              clk_in   = 1'b0;
  logic              reset    = 1'b1;
  logic              run      = 1'b1;
  logic              step_btn = 1'b0;
  logic              div_we   = 1'b0;
  logic [0:0]        div_sel  = 1'b0;
  logic [CNT_W-1:0]  div_data = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [1:0]        mode;

  tick_divider_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .SEL_W(1), .DEB_CYCLES(DEB)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run(run), .step_btn(step_btn),
    .div_we(div_we), .div_sel(div_sel), .div_data(div_data),
    .tick(tick), .sq(sq), .mode(mode)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  int         m_cnt [NUM_CH];
  int         m_div [NUM_CH];
  logic [1:0] m_tick, m_sq, m_mode;
  int         edge_n, step_due;
  logic       m_btn_prev;
  bit         m_no_step;
  logic [5:0] exp_q [$];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0;
      m_div[c] = DEF;
    end
    m_tick = '0; m_sq = '0; m_mode = 2'b00;
    edge_n = 0; step_due = -1; m_btn_prev = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [1:0] nt, ns, nm;
    bit rise, fire;
    edge_n++;
    rise = step_btn && !m_btn_prev;
    m_btn_prev = step_btn;
    if (rise && !m_no_step) step_due = edge_n + LAT;
    fire = (m_mode == 2'b01) && !run && (edge_n == step_due);
    nt = '0;
    ns = m_sq;
    for (int c = 0; c < NUM_CH; c++) begin
      if (div_we && (int'(div_sel) == c)) begin
        m_div[c] = int'(div_data);
        m_cnt[c] = 0;
      end else if (fire) begin
        m_cnt[c] = 0; nt[c] = 1'b1; ns[c] = ~ns[c];
      end else if (m_mode == 2'b00 && run) begin
        if (m_cnt[c] == m_div[c]) begin
          m_cnt[c] = 0; nt[c] = 1'b1; ns[c] = ~ns[c];
        end else begin
          m_cnt[c] = (m_cnt[c] + 1) % 256;
        end
      end
    end
    case (m_mode)
      2'b00:   nm = run ? 2'b00 : 2'b01;
      2'b01:   nm = run ? 2'b00 : (fire ? 2'b10 : 2'b01);
      default: nm = run ? 2'b00 : 2'b01;
    endcase
    m_tick = nt; m_sq = ns; m_mode = nm;
  endfunction

  task automatic cycle();
    logic [5:0] e;
    model_edge();
    exp_q.push_back({m_mode, m_sq, m_tick});
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("edge%0d mode", edge_n), mode, e[5:4]);
      check($sformatf("edge%0d sq", edge_n),   sq,   e[3:2]);
      check($sformatf("edge%0d tick", edge_n), tick, e[1:0]);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1; step_btn = 1'b0; div_we = 1'b0;
    #1;
    check({tag, " tick"}, tick, 0);
    check({tag, " sq"},   sq,   0);
    check({tag, " mode"}, mode, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_no_step = 1'b0;
    apply_reset("por");

    repeat (9) cycle();
    div_we = 1'b1; div_sel = 1'b1; div_data = 8'd0;
    cycle();
    div_we = 1'b0;
    repeat (6) cycle();

    for (int k = 0; k < 8 && m_cnt[0] != 2; k++) cycle();
    run = 1'b0;
    repeat (4) cycle();
    run = 1'b1;
    repeat (4) cycle();

    run = 1'b0;
    repeat (3) cycle();
    step_btn = 1'b1;
    repeat (20) cycle();
    step_btn = 1'b0;
    repeat (12) cycle();
`ifdef STEP_DEBOUNCE_EN
    m_no_step = 1'b1;
    step_btn = 1'b1;
    repeat (2) cycle();
    step_btn = 1'b0;
    m_no_step = 1'b0;
    repeat (10) cycle();
`endif

    step_btn = 1'b1;
    repeat (LAT) cycle();
    run = 1'b1;
    cycle();
    step_btn = 1'b0;
    repeat (8) cycle();

    for (int k = 0; k < 8 && m_cnt[0] != 3; k++) cycle();
    div_we = 1'b1; div_sel = 1'b0; div_data = 8'd5;
    cycle();
    div_we = 1'b0;
    repeat (14) cycle();

    apply_reset("mid_count");
    repeat (10) cycle();

    run = 1'b0;
    repeat (2) cycle();
    step_btn = 1'b1;
    for (int k = 0; k < LAT + 4 && m_mode != 2'b10; k++) cycle();
    apply_reset("mid_step");
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
